log2_seq: RTL and testbench

Parametrised sequential base-2 logarithm unit. Accepts an unsigned WIDTH-bit integer over a valid/ready handshake and returns floor(log2(x)) as the integer part, plus FRAC_BITS fractional bits computed by iterative squaring. It also flags zero input. It replaces the fixed 8-bit combinational power-of-two encoder: it covers the full input width, including the top bit, and sits wherever the datapath needs a log-domain value, for example gain or level computation.

---
 rtl/log2_pkg.sv | 26 ++
 rtl/log2_seq_msb_index.sv | 23 ++
 rtl/log2_seq.sv | 120 ++++++++++++
 tb/tb_log2_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log2_pkg.sv
// Shared types and helpers for the sequential log2 unit: FSM encoding,
// a reference leading-one function and the fraction-port width rule.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Reference leading-one index for values up to 32 bits; returns 0 for 0.
  function automatic int msb_index(input logic [31:0] value, input int width);
    int idx;
    idx = 0;
    for (int i = 0; i < width; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int out_frac_w(input int frac_bits);
    return (frac_bits < 1) ? 1 : frac_bits;
  endfunction

endpackage

// File: rtl/log2_seq_msb_index.sv
// Combinational leading-one priority encoder: index of the highest set bit
// of value, plus a flag for an all-zero input (index is then 0).
module msb_index #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [IW-1:0]    index,
  output logic             is_zero
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) index = IW'(i);
    end
  end

  assign is_zero = ~|value;

endmodule

// File: rtl/log2_seq.sv
// Sequential base-2 logarithm: integer part from a leading-one encoder,
// FRAC_BITS fractional bits by repeated squaring of the normalised mantissa.
module log2_seq
  import log2_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int FRAC_BITS = 4,
  localparam int IW        = $clog2(WIDTH),
  localparam int FW        = out_frac_w(FRAC_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_int,
  output logic [FW-1:0]    out_frac,
  output logic             out_zero
);

  localparam int CW = (FRAC_BITS < 2) ? 1 : $clog2(FRAC_BITS);
  localparam int SW = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    int_q;
  logic [FW-1:0]    frac_q;
  logic             zero_q;

  logic [IW-1:0]    k;
  logic             is_zero;
  logic [IW-1:0]    shamt;
  logic [SW-1:0]    sq;
  logic             sq_hi;
  logic [WIDTH-1:0] m_sq;
  logic             last_bit;
  logic             sq_lsbs_unused;

  msb_index #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_msb (
    .value   (data_q),
    .index   (k),
    .is_zero (is_zero)
  );

  // Left-justify the operand so its leading one lands on the Q1 integer bit.
  assign shamt = IW'(WIDTH - 1) - k;

  // m is Q1.(WIDTH-1), so m*m is Q2.(2*WIDTH-2); the top bit means m*m >= 2.
  assign sq    = SW'(m_q) * SW'(m_q);
  assign sq_hi = sq[SW-1];
  assign m_sq  = sq_hi ? sq[SW-1 -: WIDTH] : sq[SW-2 -: WIDTH];

  // Bits below the truncation point are intentionally dropped.
  assign sq_lsbs_unused = ^sq[WIDTH-2:0];

  assign last_bit = (int'(cnt_q) == FRAC_BITS - 1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = NORM;
      NORM: begin
        if (is_zero || FRAC_BITS == 0) state_nxt = DONE;
        else                           state_nxt = FRAC;
      end
      FRAC: if (last_bit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      int_q  <= '0;
      frac_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) data_q <= in_data;
        end
        NORM: begin
          int_q  <= k;
          frac_q <= '0;
          zero_q <= is_zero;
          m_q    <= data_q << shamt;
          cnt_q  <= '0;
        end
        FRAC: begin
          m_q    <= m_sq;
          // Shift the new bit in at the LSB; the oldest bit ends up as 2^-1.
          frac_q <= FW'({frac_q, sq_hi});
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_int   = int_q;
  assign out_frac  = (FRAC_BITS == 0) ? '0 : frac_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_log2_seq.sv
// Bench for log2_seq: directed vectors, backpressure, reset abort and
// throughput at WIDTH=8/FRAC_BITS=4, random sweeps at 8/4 and 16/8.
module tb_log2_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, FRAC_BITS=4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
  logic [7:0]  a_in_data;
  logic [2:0]  a_out_int;
  logic [3:0]  a_out_frac;

  // Instance B: WIDTH=16, FRAC_BITS=8
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [15:0] b_in_data;
  logic [3:0]  b_out_int;
  logic [7:0]  b_out_frac;

  int n_cmp = 0;
  int n_err = 0;

  log2_seq #(.WIDTH(8), .FRAC_BITS(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_int(a_out_int), .out_frac(a_out_frac), .out_zero(a_out_zero)
  );

  log2_seq #(.WIDTH(16), .FRAC_BITS(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_int(b_out_int), .out_frac(b_out_frac), .out_zero(b_out_zero)
  );

  typedef struct {
    int x;
    int ei;
    int ef;
    bit ez;
    int el;
  } vec_t;

  // Golden model: leading one by plain scan, then iterative squaring on an
  // integer-scaled mantissa with truncation to w bits.
  function automatic void ref_log2(input longint unsigned x, input int w, input int fb,
                                   output int k, output int frac, output bit z);
    longint unsigned m, sq, mask;
    k = 0; frac = 0; z = (x == 0);
    if (z) return;
    for (int i = 0; i < w; i++) if (((x >> i) & 64'd1) != 0) k = i;
    mask = (64'd1 << w) - 64'd1;
    m = (x << (w - 1 - k)) & mask;
    for (int b = 0; b < fb; b++) begin
      sq = m * m;
      if (((sq >> (2 * w - 1)) & 64'd1) != 0) begin
        frac = frac * 2 + 1;
        m = (sq >> w) & mask;
      end else begin
        frac = frac * 2;
        m = (sq >> (w - 1)) & mask;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on A; return cycles until out_valid and whether
  // in_ready was ever seen high while the operation was in flight.
  task automatic op_a(input logic [7:0] x, output int lat, output bit rdy_seen);
    a_in_data = x; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    a_in_data  = 8'($urandom);
    lat = 1;
    rdy_seen = a_in_ready;
    while (!a_out_valid && lat < 200) begin
      tick();
      lat++;
      rdy_seen |= a_in_ready;
    end
  endtask

  task automatic op_b(input logic [15:0] x, output int lat, output bit rdy_seen);
    b_in_data = x; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    b_in_data  = 16'($urandom);
    lat = 1;
    rdy_seen = b_in_ready;
    while (!b_out_valid && lat < 200) begin
      tick();
      lat++;
      rdy_seen |= b_in_ready;
    end
  endtask

  task automatic consume_a();
    a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
  endtask

  task automatic consume_b();
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_out_int, a_out_frac, a_out_zero} !== {1'b1, 1'b0, 3'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a: got rdy=%b vld=%b int=%0d frac=%0d zero=%b, expected rdy=1 vld=0 int=0 frac=0 zero=0",
               a_in_ready, a_out_valid, a_out_int, a_out_frac, a_out_zero);
    end
    n_cmp++;
    if ({b_in_ready, b_out_valid, b_out_int, b_out_frac, b_out_zero} !== {1'b1, 1'b0, 4'd0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_b: got rdy=%b vld=%b int=%0d frac=%0d zero=%b, expected rdy=1 vld=0 int=0 frac=0 zero=0",
               b_in_ready, b_out_valid, b_out_int, b_out_frac, b_out_zero);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[6];
    int   lat;
    bit   rdy;
    vecs = '{'{1, 0, 0, 0, 6}, '{128, 7, 0, 0, 6}, '{255, 7, 15, 0, 6},
             '{3, 1, 9, 0, 6}, '{96, 6, 9, 0, 6}, '{0, 0, 0, 1, 2}};
    foreach (vecs[i]) begin
      op_a(8'(vecs[i].x), lat, rdy);
      n_cmp++;
      if ({a_out_int, a_out_frac, a_out_zero} !== {3'(vecs[i].ei), 4'(vecs[i].ef), vecs[i].ez}) begin
        n_err++;
        $display("FAIL directed x=%0d: got int=%0d frac=%b zero=%b, expected int=%0d frac=%b zero=%b",
                 vecs[i].x, a_out_int, a_out_frac, a_out_zero, vecs[i].ei, 4'(vecs[i].ef), vecs[i].ez);
      end
      n_cmp++;
      if (lat !== vecs[i].el) begin
        n_err++;
        $display("FAIL latency x=%0d: got %0d cycles, expected %0d", vecs[i].x, lat, vecs[i].el);
      end
      n_cmp++;
      if (rdy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ready x=%0d: in_ready seen high while busy, expected low", vecs[i].x);
      end
      consume_a();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   rdy;
    logic seen_valid;
    op_a(8'd3, lat, rdy);
    for (int c = 0; c < 10; c++) begin
      a_in_valid = c[0];
      a_in_data  = 8'($urandom);
      tick();
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_out_int, a_out_frac, a_out_zero} !== {1'b1, 1'b0, 3'd1, 4'b1001, 1'b0}) begin
        n_err++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b int=%0d frac=%b, expected vld=1 rdy=0 int=1 frac=1001",
                 c, a_out_valid, a_in_ready, a_out_int, a_out_frac);
      end
    end
    a_in_valid = 1'b0;
    consume_a();
    n_cmp++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL release: got vld=%b rdy=%b, expected vld=0 rdy=1", a_out_valid, a_in_ready);
    end
    seen_valid = 1'b0;
    repeat (8) begin
      tick();
      seen_valid |= a_out_valid;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL no_second_accept: got out_valid=1 after release, expected 0");
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    bit   rdy;
    logic seen_valid;
    a_in_data = 8'd200; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_out_int, a_out_frac} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_err++;
      $display("FAIL abort_state: got rdy=%b vld=%b int=%0d frac=%0d, expected rdy=1 vld=0 int=0 frac=0",
               a_in_ready, a_out_valid, a_out_int, a_out_frac);
    end
    seen_valid = 1'b0;
    repeat (10) begin
      tick();
      seen_valid |= a_out_valid;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drop: got a result for the aborted operand, expected none");
    end
    op_a(8'd5, lat, rdy);
    n_cmp++;
    if ({a_out_int, a_out_frac, a_out_zero, 8'(lat)} !== {3'd2, 4'b0101, 1'b0, 8'd6}) begin
      n_err++;
      $display("FAIL after_abort x=5: got int=%0d frac=%b zero=%b lat=%0d, expected int=2 frac=0101 zero=0 lat=6",
               a_out_int, a_out_frac, a_out_zero, lat);
    end
    consume_a();
  endtask

  task automatic test_back_to_back();
    int n_acc, n_res, n_bad;
    n_acc = 0; n_res = 0; n_bad = 0;
    a_in_data = 8'd96; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (a_in_valid && a_in_ready) n_acc++;
      if (a_out_valid) begin
        n_res++;
        if ({a_out_int, a_out_frac} !== {3'd6, 4'b1001}) n_bad++;
      end
      tick();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    n_cmp++;
    if (n_acc !== 10 || n_res !== 10) begin
      n_err++;
      $display("FAIL throughput: got %0d accepts / %0d results in 70 cycles, expected 10 / 10", n_acc, n_res);
    end
    n_cmp++;
    if (n_bad !== 0) begin
      n_err++;
      $display("FAIL b2b_values: got %0d wrong results, expected 0", n_bad);
    end
    repeat (2) tick();
  endtask

  task automatic test_random_a();
    logic [7:0] x;
    int lat, ek, ef;
    bit rdy, ez;
    for (int i = 0; i < 40; i++) begin
      x = 8'(($urandom & 32'hff) >> $urandom_range(0, 8));
      ref_log2(64'(x), 8, 4, ek, ef, ez);
      op_a(x, lat, rdy);
      n_cmp++;
      if ({a_out_int, a_out_frac, a_out_zero} !== {3'(ek), 4'(ef), ez} || lat !== (ez ? 2 : 6) || rdy) begin
        n_err++;
        $display("FAIL rand_a x=%0d: got int=%0d frac=%0d zero=%b lat=%0d rdy=%b, expected int=%0d frac=%0d zero=%b lat=%0d rdy=0",
                 x, a_out_int, a_out_frac, a_out_zero, lat, rdy, ek, ef, ez, ez ? 2 : 6);
      end
      consume_a();
    end
  endtask

  task automatic test_random_b();
    logic [15:0] x;
    int lat, ek, ef;
    bit rdy, ez;
    for (int i = 0; i < 44; i++) begin
      case (i)
        0: x = 16'd0;
        1: x = 16'd1;
        2: x = 16'hffff;
        3: x = 16'h8000;
        default: x = 16'(($urandom & 32'hffff) >> $urandom_range(0, 16));
      endcase
      ref_log2(64'(x), 16, 8, ek, ef, ez);
      op_b(x, lat, rdy);
      n_cmp++;
      if ({b_out_int, b_out_frac, b_out_zero} !== {4'(ek), 8'(ef), ez} || lat !== (ez ? 2 : 10) || rdy) begin
        n_err++;
        $display("FAIL rand_b x=%0d: got int=%0d frac=%0d zero=%b lat=%0d rdy=%b, expected int=%0d frac=%0d zero=%b lat=%0d rdy=0",
                 x, b_out_int, b_out_frac, b_out_zero, lat, rdy, ek, ef, ez, ez ? 2 : 10);
      end
      consume_b();
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random_a();
    test_random_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
